pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the five-stage core. Collects stall requests from ID, EX and MEM, and produces the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. Converts exception/eret events into a one-cycle registered flush with a redirect PC. Also runs a MEM stall watchdog and a stall-cycle performance counter.

Parameters:
STALL_TIMEOUT, 255, consecutive MEM-stall cycles after which mem_timeout pulses (legal range 1..65535)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
stallreq_id  input  1  ID stage requests stall (load-use hazard)
stallreq_ex  input  1  EX stage requests stall (multi-cycle op)
stallreq_mem  input  1  MEM stage requests stall (bus wait)
excp_valid  input  1  exception committed in MEM this cycle
excp_vector  input  32  handler address for excp_valid
eret  input  1  eret committed in MEM this cycle
epc_in  input  32  return address for eret
stall  output  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb-input, bit5 wb (combinational)
flush  output  1  flush all pipeline registers (registered)
new_pc  output  32  redirect target, valid when flush=1 (registered)
mem_timeout  output  1  one-cycle watchdog pulse (registered)
stall_cycles  output  CNT_W  saturating count of cycles with stall!=0

Behaviour:
- Reset (async, rst=1): state=RUN, flush=0, new_pc=32'h0, mem_timeout=0, watchdog count=0, stall_cycles=0; stall forced to 6'b000000 while rst=1.
- States: RUN, FLUSH.
- stall (combinational, RUN only, priority MEM > EX > ID):
  - stallreq_mem: 6'b011111.
  - else stallreq_ex: 6'b001111.
  - else stallreq_id: 6'b000111.
  - else 6'b000000.
  - bit5 is never set: the stage behind the stalling stage always advances and mem_wb/ex_mem insert bubbles.
- Exception entry, RUN with excp_valid=1 or eret=1:
  - stall=0 in that cycle regardless of stall requests.
  - Next edge: state=FLUSH, flush=1, new_pc=excp_vector if excp_valid else epc_in. excp_valid wins over a simultaneous eret.
- FLUSH state:
  - Lasts exactly one cycle. flush=1, stall=0.
  - All inputs are ignored (the flushed pipeline cannot raise legitimate requests).
  - Next edge: state=RUN, flush=0, new_pc holds its value.
- Back-to-back: an exception arriving in the first RUN cycle after FLUSH is accepted normally, giving flush low for exactly one cycle between the two pulses.
- Watchdog (16-bit internal count):
  - In RUN, with no exception entry, stallreq_mem=1: count increments.
  - When count reaches STALL_TIMEOUT-1 and stallreq_mem=1: next edge mem_timeout=1 for one cycle and count=0; stall stays asserted as normal.
  - stallreq_mem=0, any exception entry, or FLUSH: count=0 next edge.
  - mem_timeout is informational; the MEM stage turns it into a bus-error exception.
- stall_cycles: increments on each edge where stall!=0; saturates at all-ones, no wrap; cleared only by rst.
- Reset asserted mid-FLUSH or mid-stall: all state is cleared immediately, and no flush pulse follows deassertion.

Test Plan:
- Reset release, all requests 0 -> stall=000000, flush=0, new_pc=0, stall_cycles=0 for 10 cycles.
- stallreq_id=1 and stallreq_ex=1 together for 3 cycles, then stallreq_mem=1 for 1 cycle -> stall=001111 (x3) then 011111, stall_cycles=4.
- excp_valid=1 with excp_vector=0xBFC00380, simultaneous eret=1 with epc_in=0x00400010 and stallreq_mem=1 -> same cycle stall=0; next cycle flush=1, new_pc=0xBFC00380; following cycle flush=0, state RUN.
- eret=1 with epc_in=0x00400020 in the cycle right after a flush pulse -> flush pattern 1,0,1, second new_pc=0x00400020.
- STALL_TIMEOUT=4, stallreq_mem held for 10 cycles -> mem_timeout pulses after the 4th and 8th stalled cycles, one cycle wide; dropping stallreq_mem at cycle 3 of a new run -> no pulse.
- CNT_W=4, stall held 20 cycles -> stall_cycles stops at 15. Async rst asserted mid-FLUSH -> flush=0 and stall_cycles=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, one-cycle registered flush with
// redirect PC, MEM-stall watchdog and saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_vector,
  input  logic             eret,
  input  logic [31:0]      epc_in,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {RUN, FLUSH} state_e;

  localparam logic [15:0] WD_LAST = 16'(STALL_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             flush_q, flush_d;
  logic [31:0]      new_pc_q, new_pc_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [15:0]      wd_cnt_q, wd_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [5:0]       stall_c;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    flush_d        = 1'b0;
    new_pc_d       = new_pc_q;
    mem_timeout_d  = 1'b0;
    wd_cnt_d       = 16'd0;
    stall_cycles_d = stall_cycles_q;
    stall_c        = 6'b000000;

    case (state_q)
      RUN: begin
        if (excp_valid || eret) begin
          state_d  = FLUSH;
          flush_d  = 1'b1;
          new_pc_d = excp_valid ? excp_vector : epc_in;
        end else begin
          if (stallreq_mem)     stall_c = 6'b011111;
          else if (stallreq_ex) stall_c = 6'b001111;
          else if (stallreq_id) stall_c = 6'b000111;

          if (stallreq_mem) begin
            if (wd_cnt_q == WD_LAST) mem_timeout_d = 1'b1;
            else                     wd_cnt_d      = wd_cnt_q + 16'd1;
          end
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase

    // Counter holds at all-ones rather than wrapping.
    if (stall_c != 6'b000000 && stall_cycles_q != {CNT_W{1'b1}})
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      flush_q        <= 1'b0;
      new_pc_q       <= 32'h0;
      mem_timeout_q  <= 1'b0;
      wd_cnt_q       <= 16'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_q        <= flush_d;
      new_pc_q       <= new_pc_d;
      mem_timeout_q  <= mem_timeout_d;
      wd_cnt_q       <= wd_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall        = rst ? 6'b000000 : stall_c;
  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
